debounce_switch: RTL

Per-bit debouncer with edge detection for the board's mechanical buttons and switches. It sits directly downstream of the two-flop synchronizer stage and consumes its already-synchronized output. A shared prescaler samples each lane at a slow rate. A lane's output changes only after N consecutive identical samples, and the block emits one-cycle rise/fall pulses for control logic such as reset requests and mode toggles.

---
 rtl/debounce_switch_pkg.sv | 34 +++
 rtl/debounce_switch_tick.sv | 33 +++
 rtl/debounce_switch.sv | 78 +++++++
 3 files changed

// File: rtl/debounce_switch_pkg.sv
// Shared helpers for the switch debouncer: prescaler counter sizing and
// classification of a lane's sample history.
package debounce_switch_pkg;

  // Widest history the classifier can look at; N must not exceed this.
  localparam int MAX_N = 32;

  // What a lane's sample history says about the next output level.
  typedef enum logic [1:0] {
    HIST_ZEROS = 2'b00,
    HIST_ONES  = 2'b01,
    HIST_MIXED = 2'b10
  } hist_class_e;

  // Prescaler counter width: enough bits to hold RATE-1, never zero bits.
  function automatic int cnt_width(input int rate);
    return (rate < 2) ? 1 : $clog2(rate);
  endfunction

  // Classify the low n bits of a history: all ones, all zeros, or mixed.
  function automatic hist_class_e classify(input logic [MAX_N-1:0] h,
                                           input int n);
    logic [MAX_N-1:0] mask;
    mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
    if ((h & mask) == mask) begin
      return HIST_ONES;
    end
    if ((h & mask) == '0) begin
      return HIST_ZEROS;
    end
    return HIST_MIXED;
  endfunction

endpackage

// File: rtl/debounce_switch_tick.sv
// Sample-rate prescaler: one-cycle tick every RATE clk cycles.
// The counter wraps exactly at RATE-1, so non-power-of-two rates are exact.
module debounce_tick
  import debounce_switch_pkg::*;
#(
  parameter int RATE = 125000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = cnt_width(RATE);
  localparam logic [CW-1:0] LAST = CW'(RATE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  // Tick is decoded straight from the count; with RATE=1 it is always high.
  assign tick = (cnt == LAST);

  // Free-running counter that restarts at zero on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/debounce_switch.sv
// Per-lane switch debouncer with registered rise/fall pulses.
// Each lane keeps the last N tick samples of its (already synchronized)
// input; the output only moves once all N samples agree, otherwise it holds.
// Lanes are independent and share only the sample-rate prescaler.
module debounce_switch
  import debounce_switch_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 3,
  parameter int RATE  = 125000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic tick;

  debounce_tick #(
    .RATE(RATE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    logic [N-1:0] hist;
    logic         lane_out;
    logic         lane_rise;
    logic         lane_fall;
    logic         next_out;
    hist_class_e  hist_class;

    // Shift in a new sample on each tick; hold the history between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hist <= '0;
      end else if (tick) begin
        hist <= {hist[N-2:0], in[k]};
      end
    end

    // Unanimous history forces the level; any disagreement keeps the old one.
    always_comb begin
      hist_class = classify(MAX_N'(hist), N);
      next_out   = lane_out;
      case (hist_class)
        HIST_ONES:  next_out = 1'b1;
        HIST_ZEROS: next_out = 1'b0;
        default:    next_out = lane_out;
      endcase
    end

    // Register the level and the edge pulses together so a pulse lines up
    // with the first cycle the new level is visible. Reset clears all three
    // at once, so a lane that was high drops without a fall pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_out  <= 1'b0;
        lane_rise <= 1'b0;
        lane_fall <= 1'b0;
      end else begin
        lane_out  <= next_out;
        lane_rise <= next_out & ~lane_out;
        lane_fall <= ~next_out & lane_out;
      end
    end

    assign out[k]  = lane_out;
    assign rise[k] = lane_rise;
    assign fall[k] = lane_fall;
  end

endmodule
